// File: rtl/sw_poll_pkg.sv
// sw_poll_pkg: shared types and constants for the switch polling controller.
//   - poll_state_e : poll sequencer states (IDLE, REQ, CAP, CMP)
//   - REG_*        : CPU register offsets
//   - CTRL_*       : CTRL register bit positions
//   - ctrl_word()  : packs the CTRL read-back value
package sw_poll_pkg;

  // Poll sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    CMP  = 2'd3
  } poll_state_e;

  // CPU register offsets
  localparam logic [1:0] REG_STABLE = 2'd0;
  localparam logic [1:0] REG_EDGE   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL layout: bit0 ENABLE, bits 4:1 DEB_COUNT read-back
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_DEB_LSB    = 1;
  localparam int unsigned CTRL_DEB_W      = 4;
  localparam int unsigned CTRL_W          = CTRL_DEB_LSB + CTRL_DEB_W;

  // Debounce counter width, enough for DEB_COUNT up to 15
  localparam int unsigned CNT_W = 4;

  // CTRL read-back value; bits above CTRL_W read as zero once extended
  function automatic logic [CTRL_W-1:0] ctrl_word(input logic enable,
                                                  input logic [CTRL_DEB_W-1:0] deb);
    return {deb, enable};
  endfunction

endpackage : sw_poll_pkg

// File: rtl/sw_debounce.sv
// sw_debounce: whole-vector debouncer for the polled switch sample.
// A new value becomes stable only after DEB_COUNT consecutive identical
// samples; any differing sample restarts the count from 1.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   upd_i        : one-cycle update strobe (poll sequencer in CMP)
//   sample_i     : captured switch sample
//   stable_o     : debounced switch value (registered)
//   chg_c_o      : bits that change in STABLE at this update (combinational,
//                  valid only while upd_i is high)
module sw_debounce
  import sw_poll_pkg::*;
#(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned DEB_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] chg_c_o
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_COUNT);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] chg_c;

  // Next candidate/count, then promote the candidate once it has held long enough
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    chg_c    = '0;
    if (upd_i) begin
      if (sample_i == cand_q) begin
        if (cnt_q < DEB_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cand_d = sample_i;
        cnt_d  = CNT_W'(1);
      end
      // Uses the updated count so DEB_COUNT=1 promotes on the first differing sample
      if ((cnt_d == DEB_MAX) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        chg_c    = stable_q ^ cand_d;
      end
    end
  end

  // Debounce state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign chg_c_o  = chg_c;

endmodule : sw_debounce

// File: rtl/sw_poll_ctrl.sv
// sw_poll_ctrl: polls the switch PIO at a fixed interval over Avalon, debounces
// the sampled vector and publishes it to the CPU with change capture and irq.
// Optional feature macro: SW_POLL_IRQ_EN (EDGE, MASK and irq implemented).
// When undefined, EDGE/MASK read 0, their writes are ignored and irq is 0.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   m_address/m_read    : Avalon master to the PIO (address always 0)
//   m_readdata          : PIO read data, valid the cycle after m_read
//   s_address/s_read/s_write/s_writedata : CPU slave access
//   s_readdata          : registered CPU read data (latency 1, held otherwise)
//   irq                 : level interrupt, OR of (EDGE AND MASK), registered
// Registers: 0 STABLE (RO), 1 EDGE (W1C), 2 MASK (RW), 3 CTRL (ENABLE, DEB_COUNT).
module sw_poll_ctrl
  import sw_poll_pkg::*;
#(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned POLL_DIV  = 50000,
  parameter int unsigned DEB_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_read,
  input  logic [WIDTH-1:0] m_readdata,
  input  logic [1:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [WIDTH-1:0] s_writedata,
  output logic [WIDTH-1:0] s_readdata,
  output logic             irq
);

  localparam int unsigned           DIV_W      = $clog2(POLL_DIV);
  localparam logic [DIV_W-1:0]      DIV_RELOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [CTRL_DEB_W-1:0] DEB_CNT    = CTRL_DEB_W'(DEB_COUNT);

  poll_state_e      state_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic             m_read_q;
  logic [WIDTH-1:0] sample_q;
  logic             upd_c;
  logic             enable_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] chg_c;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] mask_q;
  logic             irq_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             unused_c;

  // Interval divider; parked at reload while polling is disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_RELOAD;
    end else if (!enable_q || (div_q == '0)) begin
      div_q <= DIV_RELOAD;
    end else begin
      div_q <= div_q - DIV_W'(1);
    end
  end

  assign tick_c = enable_q && (div_q == '0);

  // Poll sequencer; a started poll always runs to CMP even if ENABLE drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_read_q <= 1'b0;
      sample_q <= '0;
    end else begin
      m_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            state_q  <= REQ;
            m_read_q <= 1'b1;
          end
        end
        REQ: begin
          state_q <= CAP;
        end
        CAP: begin
          sample_q <= m_readdata;
          state_q  <= CMP;
        end
        CMP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign upd_c = (state_q == CMP);

  sw_debounce #(
    .WIDTH     (WIDTH),
    .DEB_COUNT (DEB_COUNT)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .upd_i    (upd_c),
    .sample_i (sample_q),
    .stable_o (stable),
    .chg_c_o  (chg_c)
  );

  // CTRL.ENABLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b1;
    end else if (s_write && (s_address == REG_CTRL)) begin
      enable_q <= s_writedata[CTRL_ENABLE_BIT];
    end
  end

`ifdef SW_POLL_IRQ_EN
  logic [WIDTH-1:0] w1c_c;
  logic [WIDTH-1:0] edge_d;

  // Change capture; a debounce set overrides a same-cycle W1C on that bit
  always_comb begin
    w1c_c = '0;
    if (s_write && (s_address == REG_EDGE)) begin
      w1c_c = s_writedata;
    end
    edge_d = (edge_q & ~w1c_c) | chg_c;
  end

  // EDGE, MASK and the registered interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      if (s_write && (s_address == REG_MASK)) begin
        mask_q <= s_writedata;
      end
      irq_q <= |(edge_q & mask_q);
    end
  end
`else
  assign edge_q = '0;
  assign mask_q = '0;
  assign irq_q  = 1'b0;
`endif

  // Signals only partly consumed in some build configurations
  assign unused_c = ^{chg_c, s_writedata};

  // CPU read mux; the read register holds its value between reads
  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      case (s_address)
        REG_STABLE: rdata_d = stable;
        REG_EDGE:   rdata_d = edge_q;
        REG_MASK:   rdata_d = mask_q;
        default:    rdata_d = WIDTH'(ctrl_word(enable_q, DEB_CNT));
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign m_address  = 2'b00;
  assign m_read     = m_read_q;
  assign s_readdata = rdata_q;
  assign irq        = irq_q;

endmodule : sw_poll_ctrl

// File: tb/tb_sw_poll_ctrl.sv
// tb_sw_poll_ctrl: self-checking bench for sw_poll_ctrl (POLL_DIV=8, DEB_COUNT=3).
// A small PIO model answers m_read with the current switch vector one cycle later.
// Register reads push the expected value to a queue at request time and pop
// it when s_readdata becomes valid.
module tb_sw_poll_ctrl;
  import sw_poll_pkg::*;

  localparam int unsigned WIDTH     = 18;
  localparam int unsigned POLL_DIV  = 8;
  localparam int unsigned DEB_COUNT = 3;
`ifdef SW_POLL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] ALL1 = 18'h3FFFF;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [1:0]       m_address;
  logic             m_read;
  logic [WIDTH-1:0] m_readdata;
  logic [1:0]       s_address = '0;
  logic             s_read = 1'b0;
  logic             s_write = 1'b0;
  logic [WIDTH-1:0] s_writedata = '0;
  logic [WIDTH-1:0] s_readdata;
  logic             irq;
  logic [WIDTH-1:0] sw = '0;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  sw_poll_ctrl #(
    .WIDTH     (WIDTH),
    .POLL_DIV  (POLL_DIV),
    .DEB_COUNT (DEB_COUNT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq)
  );

  // PIO slave model: read latency 1
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_readdata <= '0;
    else if (m_read) m_readdata <= sw;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_read  = 1'b0;
    s_write = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [WIDTH-1:0] d);
    s_address = a;
    s_read    = 1'b1;
    tick(1);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    tick(1);
    s_write = 1'b0;
  endtask

  // Waits for n poll strobes; returns just after the edge that raised the last one
  task automatic wait_polls(input int n, output bit ok);
    ok = 1'b1;
    for (int p = 0; p < n; p++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 4 * POLL_DIV; i++) begin
        tick(1);
        if (m_read === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] rd, ex;
    sw = '0;
    reset_n = 1'b0;
    tick(2);
    checks++;
    if ({m_read, m_address, irq} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs: m_read=%b m_address=%b irq=%b expected all 0", m_read, m_address, irq);
    end
    checks++;
    if (s_readdata !== '0) begin
      failures++;
      $display("FAIL reset_readdata: got %h expected 0", s_readdata);
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 3 * POLL_DIV; n++) begin
      tick(1);
      checks++;
      if (m_read !== 1'((n % POLL_DIV) == 0)) begin
        failures++;
        $display("FAIL poll_timing cycle %0d: m_read=%b expected %b", n, m_read, (n % POLL_DIV) == 0);
      end
    end
    exp_q.push_back('0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL reset_stable: got %h expected %h", rd, ex); end
    exp_q.push_back(WIDTH'(7));
    cpu_read(REG_CTRL, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL reset_ctrl: got %h expected %h", rd, ex); end
  endtask

  task automatic test_step();
    logic [WIDTH-1:0] rd, ex;
    bit ok;
    sw = '0;
    do_reset();
    cpu_write(REG_MASK, ALL1);
    sw = ALL1;
    wait_polls(2, ok);
    tick(3);
    exp_q.push_back('0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (!ok || rd !== ex) begin failures++; $display("FAIL step_two_polls: ok=%b stable %h expected %h", ok, rd, ex); end
    wait_polls(1, ok);
    tick(2);
    checks++;
    if (!ok || irq !== 1'b0) begin failures++; $display("FAIL step_irq_cmp: ok=%b irq=%b expected 0", ok, irq); end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL step_irq_lag: irq=%b expected 0", irq); end
    tick(1);
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL step_irq: irq=%b expected %b", irq, IRQ_EN); end
    exp_q.push_back(ALL1);
    exp_q.push_back(IRQ_EN ? ALL1 : '0);
    exp_q.push_back(IRQ_EN ? ALL1 : '0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL step_stable: got %h expected %h", rd, ex); end
    cpu_read(REG_EDGE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL step_edge: got %h expected %h", rd, ex); end
    cpu_read(REG_MASK, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL step_mask: got %h expected %h", rd, ex); end
  endtask

  task automatic test_bounce();
    logic [WIDTH-1:0] rd, ex;
    bit ok;
    sw = WIDTH'(1);
    do_reset();
    cpu_write(REG_MASK, ALL1);
    for (int k = 0; k < 6; k++) begin
      wait_polls(1, ok);
      tick(1);
      sw = (sw == WIDTH'(1)) ? '0 : WIDTH'(1);
      checks++;
      if (!ok || irq !== 1'b0) begin failures++; $display("FAIL bounce_irq poll %0d: ok=%b irq=%b expected 0", k, ok, irq); end
    end
    tick(4);
    exp_q.push_back('0);
    exp_q.push_back('0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL bounce_stable: got %h expected %h", rd, ex); end
    cpu_read(REG_EDGE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL bounce_edge: got %h expected %h", rd, ex); end
  endtask

  task automatic test_set_wins();
    logic [WIDTH-1:0] rd, ex;
    bit ok;
    sw = '0;
    do_reset();
    cpu_write(REG_MASK, WIDTH'(3));
    sw = WIDTH'(3);
    wait_polls(3, ok);
    tick(2);
    cpu_write(REG_EDGE, WIDTH'(1));  // lands on the same edge as the debounce update
    exp_q.push_back(IRQ_EN ? WIDTH'(3) : '0);
    cpu_read(REG_EDGE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (!ok || rd !== ex) begin failures++; $display("FAIL set_wins_edge: ok=%b got %h expected %h", ok, rd, ex); end
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL set_wins_irq: irq=%b expected %b", irq, IRQ_EN); end
    cpu_write(REG_EDGE, WIDTH'(3));
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL w1c_irq_hold: irq=%b expected %b", irq, IRQ_EN); end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_drop: irq=%b expected 0", irq); end
    exp_q.push_back('0);
    cpu_read(REG_EDGE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL w1c_edge: got %h expected %h", rd, ex); end
  endtask

  task automatic test_enable();
    logic [WIDTH-1:0] rd, ex;
    bit ok;
    bit seen;
    sw = WIDTH'(5);
    do_reset();
    wait_polls(3, ok);
    cpu_write(REG_CTRL, '0);  // lands on the REQ edge of the third poll
    seen = 1'b0;
    for (int i = 0; i < 4 * POLL_DIV; i++) begin
      tick(1);
      if (m_read !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (!ok || seen) begin failures++; $display("FAIL disable_no_poll: ok=%b m_read_seen=%b expected 0", ok, seen); end
    exp_q.push_back(WIDTH'(5));
    exp_q.push_back(WIDTH'(6));
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL disable_poll_completes: stable %h expected %h", rd, ex); end
    cpu_read(REG_CTRL, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL disable_ctrl: got %h expected %h", rd, ex); end
    cpu_write(REG_CTRL, WIDTH'(1));
    for (int k = 1; k <= POLL_DIV; k++) begin
      tick(1);
      checks++;
      if (m_read !== 1'(k == POLL_DIV)) begin
        failures++;
        $display("FAIL reenable_timing cycle %0d: m_read=%b expected %b", k, m_read, k == POLL_DIV);
      end
    end
  endtask

  task automatic test_reset_mid_poll();
    logic [WIDTH-1:0] rd, ex;
    bit ok;
    sw = ALL1;
    do_reset();
    cpu_write(REG_MASK, ALL1);
    wait_polls(2, ok);
    exp_q.push_back(WIDTH'(7));
    cpu_read(REG_CTRL, rd);
    ex = exp_q.pop_front();
    checks++;
    if (!ok || rd !== ex) begin failures++; $display("FAIL midreset_pre_ctrl: ok=%b got %h expected %h", ok, rd, ex); end
    wait_polls(1, ok);
    tick(1);  // third poll now in CAP
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {m_read, irq} !== 2'b00) begin failures++; $display("FAIL midreset_outputs: ok=%b m_read=%b irq=%b expected 0", ok, m_read, irq); end
    checks++;
    if (s_readdata !== '0) begin failures++; $display("FAIL midreset_readdata: got %h expected 0", s_readdata); end
    tick(1);
    reset_n = 1'b1;
    for (int n = 1; n <= POLL_DIV; n++) begin
      tick(1);
      checks++;
      if (m_read !== 1'(n == POLL_DIV)) begin
        failures++;
        $display("FAIL midreset_first_poll cycle %0d: m_read=%b expected %b", n, m_read, n == POLL_DIV);
      end
    end
    exp_q.push_back('0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL midreset_stable: got %h expected %h", rd, ex); end
    wait_polls(1, ok);
    tick(4);
    exp_q.push_back('0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (!ok || rd !== ex) begin failures++; $display("FAIL midreset_fresh_count: ok=%b stable %h expected %h", ok, rd, ex); end
    wait_polls(1, ok);
    tick(4);
    exp_q.push_back(ALL1);
    exp_q.push_back(IRQ_EN ? ALL1 : '0);
    cpu_read(REG_STABLE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (!ok || rd !== ex) begin failures++; $display("FAIL midreset_recover: ok=%b stable %h expected %h", ok, rd, ex); end
    cpu_read(REG_EDGE, rd);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin failures++; $display("FAIL midreset_edge: got %h expected %h", rd, ex); end
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL midreset_irq: irq=%b expected %b", irq, IRQ_EN); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_set_wins();
    test_enable();
    test_reset_mid_poll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sw_poll_ctrl
